req_encoder16: RTL and testbench
================================

REQ_ENCODER16 -- requirements
Module: req_encoder16

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 E  input  1  offer enable; when 0, no new code is offered.
REQ-005 req  input  16  one-hot-or-multi request lines, sampled on every rising edge of clk.
REQ-006 ack  input  1  consumer accepts the offered code; meaningful only while V=1.
REQ-007 S  output  4  encoded index of the offered request; bit order matches Decoder4t16 select S.
REQ-008 V  output  1  S is valid and held.
REQ-009 P  output  16  current pending-request register.
REQ-010 OVF  output  1  sticky flag: a request arrived for an already-pending index.

Function
REQ-011 Pending update per edge: P[i] next = req[i] | (P[i] & ~clr[i]), where clr[i] = V & ack & (S==i).
REQ-012 A request and a clear on the same index in the same cycle SHALL leave P[i]=1.
REQ-013 OVF SHALL set on any edge where req[i]=1 and P[i]=1 and clr[i]=0, for any i.
REQ-014 OVF SHALL hold until reset.
REQ-015 Priority: highest set index wins; index 15 highest, index 0 lowest.
REQ-016 FSM states: IDLE (V=0) and OFFER (V=1); S, V, and state SHALL be registered.
REQ-017 IDLE -> OFFER when E=1 and P!=0; S loads the top index of P.
REQ-018 In IDLE, requests arriving this edge SHALL NOT be offered until the following edge.
REQ-019 OFFER, ack=0: S and V SHALL hold unchanged, even if a higher-priority request arrives or E drops.
REQ-020 OFFER, ack=1, E=1, (P with bit S cleared) != 0: SHALL stay in OFFER; S loads the top index of (P & ~clr); zero bubble.
REQ-021 OFFER, ack=1, and either E=0 or (P & ~clr)==0: SHALL go to IDLE with V=0; S holds its last value.
REQ-022 Latency: req at edge n -> P at edge n -> V=1 at edge n+1 when idle and E=1.
REQ-023 ack while V=0 SHALL be ignored: no clear, no state change.
REQ-024 E=0 SHALL NOT block pending accumulation or OVF detection.
REQ-025 All 16 requests simultaneously: codes SHALL be offered 15,14,...,0 on 16 consecutive acked cycles.

Reset
REQ-026 rst_n=0 SHALL immediately force P=0, S=0, V=0, OVF=0, and state=IDLE, independent of clk.
REQ-027 Reset asserted mid-offer SHALL discard all pending requests; no code is offered after release until new req.
REQ-028 The first edge after rst_n rises SHALL sample req normally.

Verification
REQ-029 Single request: E=1, req=0x0020 for one cycle, ack=0 -> P=0x0020, then V=1, S=5; V and S hold for 10 cycles.
REQ-030 Priority and handshake: req=0x8101 for one cycle, ack held 1 -> S=15, 8, 0 on consecutive cycles, then V=0 and P=0.
REQ-031 Hold under preemption: offering S=3, no ack, req=0x4000 arrives -> S stays 3; after ack, S=14.
REQ-032 Re-request on clear: offering S=7, ack=1 and req=0x0080 on the same edge -> P[7] stays 1, OVF=0, S=7 offered again next.
REQ-033 Overflow and enable: E=0, req=0x0002 on two consecutive cycles -> OVF=1, V=0, P=0x0002; E=1 -> V=1, S=1.
REQ-034 Async reset: rst_n pulsed low between edges during OFFER with P=0xFFFF -> P=0, V=0, OVF=0 before the next edge.

Source files
------------

// File: rtl/req_encoder16.sv
// req_encoder16 -- 16-input request accumulator with a priority-encoded offer handshake.
//
// Each incoming request bit is latched into a pending register (P). When E is high,
// the highest set pending index is offered on S with V=1. The offer stays fixed until
// the consumer acks it. An ack clears that pending bit, and the next-highest remaining
// index is offered on the same edge, with no bubble. OVF is a sticky flag. It sets when a
// request arrives for an index that is already pending and is not being cleared on
// that edge.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   E      in   1   offer enable (does not gate accumulation or OVF)
//   req    in  16   request lines, sampled every edge
//   ack    in   1   consumer accepts current offer (ignored while V=0)
//   S      out  4   offered index (registered, holds when V drops)
//   V      out  1   offer valid (registered)
//   P      out 16   pending-request register
//   OVF    out  1   sticky overflow flag
module req_encoder16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        E,
    input  logic [15:0] req,
    input  logic        ack,
    output logic [3:0]  S,
    output logic        V,
    output logic [15:0] P,
    output logic        OVF
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e      state_q;
    logic [3:0]  s_q;
    logic        v_q;
    logic [15:0] p_q, p_d;
    logic        ovf_q, ovf_d;
    logic [15:0] clr;
    logic [15:0] rem;

    // Highest set bit wins. A later loop iteration overrides an earlier one.
    function automatic logic [3:0] top_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) idx = i[3:0];
        end
        return idx;
    endfunction

    // The clear applies only to a live offer that is acked in this cycle.
    always_comb begin
        clr = 16'h0000;
        if (v_q && ack) clr = 16'h0001 << s_q;
    end

    // rem is P after the clear and before the new requests are merged in. A request
    // that lands on the index being cleared re-sets that bit. It does not count as overflow.
    assign rem   = p_q & ~clr;
    assign p_d   = req | rem;
    assign ovf_d = ovf_q | (|(req & rem));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= 16'h0000;
            ovf_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            ovf_q <= ovf_d;
        end
    end

    // The offer FSM looks only at P as it stood before this edge. Requests that arrive
    // on the same edge cannot be offered until the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            v_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (E && (p_q != 16'h0000)) begin
                        state_q <= OFFER;
                        s_q     <= top_idx(p_q);
                        v_q     <= 1'b1;
                    end
                end
                OFFER: begin
                    // Without an ack the offer is frozen. Preemption and E are ignored here.
                    if (ack) begin
                        if (E && (rem != 16'h0000)) begin
                            s_q <= top_idx(rem);
                        end else begin
                            state_q <= IDLE;
                            v_q     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    v_q     <= 1'b0;
                end
            endcase
        end
    end

    assign S   = s_q;
    assign V   = v_q;
    assign P   = p_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_req_encoder16.sv
// Testbench for req_encoder16. It uses directed vector tables, hand-built corner
// sequences, and randomized traffic, all checked against an array-based model of the
// pending/offer rules.
module tb_req_encoder16;

    logic        clk;
    logic        rst_n;
    logic        E;
    logic [15:0] req;
    logic        ack;
    logic [3:0]  S;
    logic        V;
    logic [15:0] P;
    logic        OVF;

    int total = 0;
    int bad   = 0;

    req_encoder16 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .E    (E),
        .req  (req),
        .ack  (ack),
        .S    (S),
        .V    (V),
        .P    (P),
        .OVF  (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_pend [16];
    bit m_v;
    int m_s;
    bit m_ovf;

    function automatic int highest(input bit a [16]);
        int h;
        h = -1;
        for (int i = 0; i < 16; i++) if (a[i]) h = i;
        return h;
    endfunction

    function automatic logic [15:0] pend_vec();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = m_pend[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_v   = 0;
        m_s   = 0;
        m_ovf = 0;
    endtask

    task automatic model_step(input logic e, input logic [15:0] r, input logic a);
        bit old [16];
        bit left [16];
        int cidx;
        old  = m_pend;
        cidx = (m_v && a) ? m_s : -1;
        for (int i = 0; i < 16; i++) left[i] = old[i] && (i != cidx);
        for (int i = 0; i < 16; i++) begin
            if (r[i] && left[i]) m_ovf = 1;
            m_pend[i] = r[i] || left[i];
        end
        if (!m_v) begin
            if (e && highest(old) >= 0) begin
                m_v = 1;
                m_s = highest(old);
            end
        end else if (a) begin
            if (e && highest(left) >= 0) m_s = highest(left);
            else                         m_v = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic chk_model();
        chk("mdl_S",   {28'd0, S},   m_s);
        chk("mdl_V",   {31'd0, V},   {31'd0, m_v});
        chk("mdl_P",   {16'd0, P},   {16'd0, pend_vec()});
        chk("mdl_OVF", {31'd0, OVF}, {31'd0, m_ovf});
    endtask

    // Called at a negedge. It drives the inputs, takes one posedge, then checks
    // the DUT against the model, and returns at the next negedge.
    task automatic cycle(input logic e, input logic [15:0] r, input logic a);
        E = e; req = r; ack = a;
        @(posedge clk);
        model_step(e, r, a);
        #1;
        chk_model();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; E = 1'b0; req = '0; ack = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_S",   {28'd0, S},   32'd0);
        chk("rst_V",   {31'd0, V},   32'd0);
        chk("rst_P",   {16'd0, P},   32'd0);
        chk("rst_OVF", {31'd0, OVF}, 32'd0);
    endtask

    typedef struct {
        logic        e;
        logic [15:0] r;
        logic        a;
        logic [3:0]  s;
        logic        v;
        logic [15:0] p;
        logic        o;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic [15:0] r, input logic a,
                       input logic [3:0] s, input logic v, input logic [15:0] p, input logic o);
        vec_t t;
        t.e = e; t.r = r; t.a = a; t.s = s; t.v = v; t.p = p; t.o = o;
        tbl.push_back(t);
    endtask

    initial begin
        rst_n = 1'b0; E = 1'b0; req = '0; ack = 1'b0;
        model_reset();

        //   E  req       ack  S    V  P         OVF
        // single request, offered one edge later, held without ack
        add(1, 16'h0020, 0, 4'd0,  0, 16'h0020, 0);
        add(1, 16'h0000, 0, 4'd5,  1, 16'h0020, 0);
        for (int k = 0; k < 10; k++)
            add(1, 16'h0000, 0, 4'd5, 1, 16'h0020, 0);
        add(1, 16'h0000, 1, 4'd5,  0, 16'h0000, 0);
        // priority 15,8,0 with ack held (the first ack arrives while V=0 and is ignored)
        add(1, 16'h8101, 1, 4'd5,  0, 16'h8101, 0);
        add(1, 16'h0000, 1, 4'd15, 1, 16'h8101, 0);
        add(1, 16'h0000, 1, 4'd8,  1, 16'h0101, 0);
        add(1, 16'h0000, 1, 4'd0,  1, 16'h0001, 0);
        add(1, 16'h0000, 1, 4'd0,  0, 16'h0000, 0);
        // hold under preemption
        add(1, 16'h0008, 0, 4'd0,  0, 16'h0008, 0);
        add(1, 16'h0000, 0, 4'd3,  1, 16'h0008, 0);
        add(1, 16'h4000, 0, 4'd3,  1, 16'h4008, 0);
        add(1, 16'h0000, 0, 4'd3,  1, 16'h4008, 0);
        add(1, 16'h0000, 1, 4'd14, 1, 16'h4000, 0);
        add(1, 16'h0000, 1, 4'd14, 0, 16'h0000, 0);
        // re-request on the index being cleared
        add(1, 16'h0080, 0, 4'd14, 0, 16'h0080, 0);
        add(1, 16'h0000, 0, 4'd7,  1, 16'h0080, 0);
        add(1, 16'h0080, 1, 4'd7,  0, 16'h0080, 0);
        add(1, 16'h0000, 0, 4'd7,  1, 16'h0080, 0);
        add(1, 16'h0000, 1, 4'd7,  0, 16'h0000, 0);
        // overflow while disabled, then enable, E drop during an offer
        add(0, 16'h0002, 0, 4'd7,  0, 16'h0002, 0);
        add(0, 16'h0002, 0, 4'd7,  0, 16'h0002, 1);
        add(0, 16'h0000, 0, 4'd7,  0, 16'h0002, 1);
        add(1, 16'h0000, 0, 4'd1,  1, 16'h0002, 1);
        add(0, 16'h0000, 0, 4'd1,  1, 16'h0002, 1);
        add(0, 16'h0000, 1, 4'd1,  0, 16'h0000, 1);

        reset_dut();
        foreach (tbl[i]) begin
            cycle(tbl[i].e, tbl[i].r, tbl[i].a);
            chk($sformatf("tbl%0d_S", i),   {28'd0, S},   {28'd0, tbl[i].s});
            chk($sformatf("tbl%0d_V", i),   {31'd0, V},   {31'd0, tbl[i].v});
            chk($sformatf("tbl%0d_P", i),   {16'd0, P},   {16'd0, tbl[i].p});
            chk($sformatf("tbl%0d_OVF", i), {31'd0, OVF}, {31'd0, tbl[i].o});
        end

        // all 16 at once, drained 15..0 with no bubble
        reset_dut();
        cycle(1, 16'hFFFF, 0);
        chk("all_P", {16'd0, P}, 32'h0000FFFF);
        cycle(1, 16'h0000, 1);
        chk("all_first", {27'd0, V, S}, {27'd0, 1'b1, 4'd15});
        for (int k = 14; k >= 0; k--) begin
            cycle(1, 16'h0000, 1);
            chk($sformatf("all_S%0d", k), {27'd0, V, S}, {27'd0, 1'b1, k[3:0]});
        end
        cycle(1, 16'h0000, 1);
        chk("all_done_V", {31'd0, V}, 32'd0);
        chk("all_done_P", {16'd0, P}, 32'd0);

        // asynchronous reset between edges in the middle of an offer
        cycle(1, 16'hFFFF, 0);
        cycle(1, 16'hFFFF, 0);
        chk("pre_ar", {10'd0, OVF, V, S, P}, {10'd0, 1'b1, 1'b1, 4'd15, 16'hFFFF});
        rst_n = 1'b0;
        #1;
        chk("ar_P",   {16'd0, P},   32'd0);
        chk("ar_V",   {31'd0, V},   32'd0);
        chk("ar_OVF", {31'd0, OVF}, 32'd0);
        chk("ar_S",   {28'd0, S},   32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1, 16'h0000, 0);
            chk("post_ar_idle", {15'd0, V, P}, 32'd0);
        end

        // the first edge after release samples req
        reset_dut();
        cycle(1, 16'h0010, 0);
        chk("first_edge_P", {16'd0, P}, 32'h00000010);
        cycle(1, 16'h0000, 0);
        chk("first_edge_off", {27'd0, V, S}, {27'd0, 1'b1, 4'd4});

        // randomized traffic against the model
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            logic [15:0] r;
            r = '0;
            for (int b = 0; b < 16; b++) r[b] = ($urandom_range(0, 11) == 0);
            cycle(($urandom_range(0, 5) != 0), r, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
